sar_adc_sampler: RTL and testbench

// - Initiator side of the SAR_ADC start/den handshake. Issues periodic start pulses and captures

---
 rtl/sar_pkg.sv | 18 +
 rtl/sar_avg_acc.sv | 43 ++++
 rtl/sar_adc_sampler.sv | 142 ++++++++++++++
 tb/tb_sar_adc_sampler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and sizing helpers for the SAR ADC sampler and its averaging datapath.
package sar_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SLOT,
        S_TRIG,
        S_CONV
    } sar_smp_state_t;

    localparam int SAR_ADC_WIDTH = 8;

    // Bits needed to hold any value in 0..maxVal, never less than one.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/sar_avg_acc.sv
// Sums 2**AVG_LOG2 converter results and flags the sample that completes an average,
// presenting the truncated mean of the completed block in the same cycle.
module sar_avg_acc
    import sar_pkg::*;
#(
    parameter int ADC_WIDTH = SAR_ADC_WIDTH,
    parameter int AVG_LOG2  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_sample,
    input  logic [ADC_WIDTH-1:0] i_data,
    output logic                 o_done,
    output logic [ADC_WIDTH-1:0] o_avg
);

    localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
    localparam int CNT_W = cntWidth((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_shifted;

    assign w_sum     = r_acc + ACC_W'(i_data);
    assign w_shifted = w_sum >> AVG_LOG2;
    assign o_avg     = w_shifted[ADC_WIDTH-1:0];
    assign o_done    = i_sample && (r_count == LAST_IDX);

    // The completing sample is folded into o_avg directly, so the registers restart at zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear || o_done) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (i_sample) begin
            r_acc   <= w_sum;
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sar_adc_sampler.sv
// Initiator side of the SAR ADC start/den handshake: paces start pulses, watches for
// converter timeouts and hands averaged results downstream over valid/ready.
module sar_adc_sampler
    import sar_pkg::*;
#(
    parameter int ADC_WIDTH = SAR_ADC_WIDTH,
    parameter int AVG_LOG2  = 2,
    parameter int PERIOD    = 64,
    parameter int TIMEOUT   = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    output logic                 o_start,
    input  logic                 i_eoc,
    input  logic                 i_den,
    input  logic [ADC_WIDTH-1:0] i_dout,
    output logic [ADC_WIDTH-1:0] o_avg_data,
    output logic                 o_avg_valid,
    input  logic                 i_avg_ready,
    output logic                 o_overrun,
    output logic                 o_timeout_err
);

    localparam int PER_W = cntWidth(PERIOD - 1);
    localparam int TO_W  = cntWidth(TIMEOUT - 1);
    localparam logic [PER_W-1:0] PER_LOAD = PER_W'(PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    sar_smp_state_t r_state;
    sar_smp_state_t w_nextState;

    logic [PER_W-1:0]     r_periodCnt;
    logic [TO_W-1:0]      r_timeoutCnt;
    logic [ADC_WIDTH-1:0] r_avgData;
    logic                 r_avgValid;
    logic                 r_overrun;

    logic                 w_slotDue;
    logic                 w_start;
    logic                 w_sample;
    logic                 w_timeout;
    logic                 w_accClear;
    logic                 w_done;
    logic [ADC_WIDTH-1:0] w_avg;

    assign w_slotDue = (r_state == S_SLOT) && (r_periodCnt == '0) && i_eoc;

    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_sample    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: if (i_en) w_nextState = S_SLOT;
            S_SLOT: if (w_slotDue) w_nextState = S_TRIG;
            S_TRIG: begin
                w_start     = 1'b1;
                w_nextState = S_CONV;
            end
            S_CONV: begin
                if (i_den) begin
                    w_sample    = 1'b1;
                    w_nextState = S_SLOT;
                end else if (r_timeoutCnt == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_nextState = S_SLOT;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
        if (!i_en) begin
            w_nextState = S_IDLE;
            w_start     = 1'b0;
            w_sample    = 1'b0;
            w_timeout   = 1'b0;
        end
    end

    // Both counters are loaded on entry to TRIG so the TRIG cycle itself counts as the
    // first clock of the period and of the timeout window.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_periodCnt  <= '0;
            r_timeoutCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (!i_en || r_state == S_IDLE) begin
                r_periodCnt  <= '0;
                r_timeoutCnt <= '0;
            end else if (w_slotDue) begin
                r_periodCnt  <= PER_LOAD;
                r_timeoutCnt <= '0;
            end else begin
                if (r_periodCnt != '0) r_periodCnt <= r_periodCnt - PER_W'(1);
                if ((r_state == S_TRIG || r_state == S_CONV) && r_timeoutCnt != TO_LAST)
                    r_timeoutCnt <= r_timeoutCnt + TO_W'(1);
            end
        end
    end

    assign w_accClear = !i_en || w_timeout || (r_state == S_IDLE);

    sar_avg_acc #(
        .ADC_WIDTH (ADC_WIDTH),
        .AVG_LOG2  (AVG_LOG2)
    ) u_avgAcc (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_accClear),
        .i_sample (w_sample),
        .i_data   (i_dout),
        .o_done   (w_done),
        .o_avg    (w_avg)
    );

    // A fresh average always wins over the ready handshake; losing an unaccepted one is sticky.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_avgData  <= '0;
            r_avgValid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_done) begin
                r_avgData  <= w_avg;
                r_avgValid <= 1'b1;
                if (r_avgValid && !i_avg_ready) r_overrun <= 1'b1;
            end else if (r_avgValid && i_avg_ready) begin
                r_avgValid <= 1'b0;
            end
            if (!i_en) r_overrun <= 1'b0;
        end
    end

    assign o_start       = w_start;
    assign o_timeout_err = w_timeout;
    assign o_avg_data    = r_avgData;
    assign o_avg_valid   = r_avgValid;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_sar_adc_sampler.sv
// Directed bench: a 4-sample averaging sampler driven by a den/Dout responder, plus a
// non-averaging instance with downstream ready tied high.
`timescale 1ns/1ps
module tb_sar_adc_sampler;

    localparam int W      = 8;
    localparam int PERIOD = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rstN, en, eoc, den, ready;
    logic [W-1:0] dout;
    logic         start, avgValid, overrun, timeoutErr;
    logic [W-1:0] avgData;

    logic         bEn, bDen;
    logic [W-1:0] bDout;
    logic         bStart, bAvgValid, bOverrun, bTimeout;
    logic [W-1:0] bAvgData;

    int numCompared   = 0;
    int numMismatched = 0;

    sar_adc_sampler #(
        .ADC_WIDTH (W),
        .AVG_LOG2  (2),
        .PERIOD    (PERIOD),
        .TIMEOUT   (32)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_en          (en),
        .o_start       (start),
        .i_eoc         (eoc),
        .i_den         (den),
        .i_dout        (dout),
        .o_avg_data    (avgData),
        .o_avg_valid   (avgValid),
        .i_avg_ready   (ready),
        .o_overrun     (overrun),
        .o_timeout_err (timeoutErr)
    );

    sar_adc_sampler #(
        .ADC_WIDTH (W),
        .AVG_LOG2  (0),
        .PERIOD    (16),
        .TIMEOUT   (8)
    ) dutNoAvg (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_en          (bEn),
        .o_start       (bStart),
        .i_eoc         (1'b1),
        .i_den         (bDen),
        .i_dout        (bDout),
        .o_avg_data    (bAvgData),
        .o_avg_valid   (bAvgValid),
        .i_avg_ready   (1'b1),
        .o_overrun     (bOverrun),
        .o_timeout_err (bTimeout)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        numCompared++;
        if (actual != expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic waitStart(output int tStart);
        bit seen = 1'b0;
        tStart = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (start) begin
                seen   = 1'b1;
                tStart = cyc;
            end
        end
        if (!seen) checkOutput("startSeen", 0, 1);
    endtask

    task automatic finishConv(input logic [W-1:0] data, input int delay);
        repeat (delay) @(negedge clk);
        den  = 1'b1;
        dout = data;
        @(negedge clk);
        den  = 1'b0;
    endtask

    task automatic applyStimulus(input logic [W-1:0] data, input int delay, output int tStart);
        waitStart(tStart);
        if (tStart >= 0) finishConv(data, delay);
    endtask

    // Four conversions, den 9 clocks after each start; vals holds sample k in byte k.
    task automatic runAverage(input string tag, input logic [31:0] vals, input int expAvg,
                              input bit expPendValid, input bit expOverrun, output int tFirst);
        int tPrev = 0;
        int tNow;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(vals[8*k +: 8], 9, tNow);
            if (k == 0) tFirst = tNow;
            else checkOutput({tag, "_period"}, tNow - tPrev, PERIOD);
            tPrev = tNow;
            if (k < 3) begin
                checkOutput({tag, "_pending"}, int'(avgValid), int'(expPendValid));
            end else begin
                checkOutput({tag, "_valid"}, int'(avgValid), 1);
                checkOutput({tag, "_data"}, int'(avgData), expAvg);
                checkOutput({tag, "_overrun"}, int'(overrun), int'(expOverrun));
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int tEn, tFirst, tTo, tNext, startCount;
        logic [W-1:0] bVals [3];
        bit found;

        rstN = 1'b0; en = 1'b0; eoc = 1'b1; den = 1'b0; dout = '0; ready = 1'b0;
        bEn = 1'b0; bDen = 1'b0; bDout = '0;
        repeat (3) @(negedge clk);
        checkOutput("rstStart", int'(start), 0);
        checkOutput("rstValid", int'(avgValid), 0);
        checkOutput("rstData", int'(avgData), 0);
        checkOutput("rstOverrun", int'(overrun), 0);
        checkOutput("rstTimeout", int'(timeoutErr), 0);
        rstN = 1'b1;

        // No averaging: every den yields a one-cycle valid pulse carrying Dout itself.
        bVals[0] = 8'hFF; bVals[1] = 8'h5A; bVals[2] = 8'h00;
        bEn = 1'b1;
        for (int s = 0; s < 3; s++) begin
            found = 1'b0;
            for (int i = 0; i < 50 && !found; i++) begin
                @(negedge clk);
                if (bStart) found = 1'b1;
            end
            if (!found) checkOutput("bStartSeen", 0, 1);
            repeat (3) @(negedge clk);
            bDen = 1'b1; bDout = bVals[s];
            @(negedge clk);
            bDen = 1'b0;
            checkOutput("bValid", int'(bAvgValid), 1);
            checkOutput("bData", int'(bAvgData), int'(bVals[s]));
            @(negedge clk);
            checkOutput("bValidDrop", int'(bAvgValid), 0);
        end
        bEn = 1'b0;
        @(negedge clk);
        checkOutput("bOverrun", int'(bOverrun), 0);
        checkOutput("bTimeout", int'(bTimeout), 0);

        // 10,20,30,41 -> 101/4 = 25
        en = 1'b1; tEn = cyc;
        runAverage("avg25", {8'd41, 8'd30, 8'd20, 8'd10}, 25, 1'b0, 1'b0, tFirst);
        checkOutput("firstStart", tFirst - tEn, 2);
        repeat (5) @(negedge clk);
        checkOutput("heldValid", int'(avgValid), 1);
        checkOutput("heldData", int'(avgData), 25);

        // Second average lands while the first is still unaccepted: 404/4 = 101
        runAverage("ovr", {8'd104, 8'd100, 8'd100, 8'd100}, 101, 1'b1, 1'b1, tFirst);

        en = 1'b0;
        @(negedge clk);
        checkOutput("enOffOverrun", int'(overrun), 0);
        checkOutput("enOffValid", int'(avgValid), 1);
        checkOutput("enOffData", int'(avgData), 101);
        startCount = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (start) startCount++;
        end
        checkOutput("idleNoStart", startCount, 0);
        ready = 1'b1;
        @(negedge clk);
        checkOutput("acceptDrop", int'(avgValid), 0);

        en = 1'b1;
        runAverage("max", {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 255, 1'b0, 1'b0, tFirst);
        // 3+2+1+1 = 7, 7/4 truncates to 1
        runAverage("trunc", {8'd1, 8'd1, 8'd2, 8'd3}, 1, 1'b0, 1'b0, tFirst);

        // A partial sum of 200 is thrown away by the timeout that follows it.
        applyStimulus(8'd200, 9, tNext);
        checkOutput("toPartial", int'(avgValid), 0);
        waitStart(tTo);
        repeat (30) @(negedge clk);
        checkOutput("toBefore", int'(timeoutErr), 0);
        @(negedge clk);
        checkOutput("toPulse", int'(timeoutErr), 1);
        checkOutput("toNoValid", int'(avgValid), 0);
        @(negedge clk);
        checkOutput("toAfter", int'(timeoutErr), 0);
        waitStart(tNext);
        checkOutput("toNextStart", tNext - tTo, PERIOD);
        finishConv(8'd4, 9);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(8'd4, 9, tNext);
            if (k < 2) checkOutput("toPending", int'(avgValid), 0);
        end
        checkOutput("toAvgValid", int'(avgValid), 1);
        checkOutput("toAvgData", int'(avgData), 4);

        // Converter busy for 100 clocks at the slot boundary.
        ready = 1'b0;
        eoc = 1'b0;
        startCount = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (start) startCount++;
        end
        checkOutput("eocLowNoStart", startCount, 0);
        eoc = 1'b1;
        @(negedge clk);
        checkOutput("eocLateStart", int'(start), 1);
        finishConv(8'd8, 9);
        for (int k = 0; k < 3; k++) applyStimulus(8'd8, 9, tNext);
        checkOutput("eocAvgValid", int'(avgValid), 1);
        checkOutput("eocAvgData", int'(avgData), 8);

        // Reset in the middle of a conversion, then a stale den while the FSM restarts.
        waitStart(tTo);
        repeat (3) @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("midRstStart", int'(start), 0);
        checkOutput("midRstValid", int'(avgValid), 0);
        checkOutput("midRstData", int'(avgData), 0);
        checkOutput("midRstOverrun", int'(overrun), 0);
        checkOutput("midRstTimeout", int'(timeoutErr), 0);
        rstN = 1'b1;
        den = 1'b1; dout = 8'd200;
        @(negedge clk);
        den = 1'b0;
        runAverage("postRst", {8'd40, 8'd40, 8'd40, 8'd40}, 40, 1'b0, 1'b0, tFirst);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
